// File: rtl/multiplier_8bit.sv
// Sequential 8x8 shift-add multiplier with addend: product = multiplicand * multiplier + addend.
// Data-independent latency of 8 CALC cycles; shares the divider's strt/idle handshake.
module multiplier_8bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        strt,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  input  logic [7:0]  addend,
  output logic [15:0] product,
  output logic        done,
  output logic        idle
);

  // state  | meaning
  // S_IDLE | waiting for strt, operands captured on the accepting edge
  // S_CALC | one shift-add iteration per cycle, count 0..7
  // S_DONE | product valid, done pulses for this single cycle
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b11,
    S_DONE = 2'b10
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] acc;
  logic [15:0] acc_nxt;
  logic [7:0]  mcand_reg;
  logic [7:0]  mplier_reg;
  logic [2:0]  count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The unused code 01 falls through to the default and recovers to IDLE.
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = strt ? S_CALC : S_IDLE;
      S_CALC:  state_nxt = (count == 3'd7) ? S_DONE : S_CALC;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    idle = (state == S_IDLE);
    done = (state == S_DONE);
  end

  always_comb begin
    acc_nxt = acc;
    if (mplier_reg[0]) begin
      acc_nxt = acc + ({8'd0, mcand_reg} << count);
    end
  end

  // The final iteration's add is folded straight into product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      product    <= 16'd0;
      acc        <= 16'd0;
      count      <= 3'd0;
      mplier_reg <= 8'd0;
      mcand_reg  <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (strt) begin
            mcand_reg  <= multiplicand;
            mplier_reg <= multiplier;
            acc        <= {8'd0, addend};
            count      <= 3'd0;
          end
        end
        S_CALC: begin
          acc        <= acc_nxt;
          mplier_reg <= mplier_reg >> 1;
          count      <= count + 3'd1;
          if (count == 3'd7) begin
            product <= acc_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_8bit.sv
// Scoreboard bench for multiplier_8bit: accepted requests push A*B+addend, a done monitor pops and compares.
module tb_multiplier_8bit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        strt = 1'b0;
  logic [7:0]  a = 8'd0;
  logic [7:0]  b = 8'd0;
  logic [7:0]  c = 8'd0;
  logic [15:0] product;
  logic        done;
  logic        idle;

  multiplier_8bit dut (
    .clk(clk), .rst(rst), .strt(strt),
    .multiplicand(a), .multiplier(b), .addend(c),
    .product(product), .done(done), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned exp;
    int          start;
  } txn_t;

  txn_t sb[$];
  int   accepts[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Request acceptance: strt seen with idle high will be taken on the next rising edge.
  always @(negedge clk) begin
    if (rst && strt && idle) begin
      txn_t t;
      t.exp   = 32'(a) * 32'(b) + 32'(c);
      t.start = cyc + 1;
      sb.push_back(t);
      accepts.push_back(cyc + 1);
    end
  end

  always @(negedge clk) begin
    if (prev_done) check("idle_after_done", 32'(idle), 1);
    prev_done = done;
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: done=1 with no outstanding request, product=%0d", product);
      end else begin
        txn_t t;
        t = sb.pop_front();
        check("product", 32'(product), t.exp);
        check("latency_edges", 32'(cyc - t.start), 8);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!idle && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!idle) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: idle=%0b after %0d cycles, expected 1", idle, n);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    wait_idle();
  endtask

  task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic [7:0] xc,
                        input bit scramble);
    wait_idle();
    a = xa; b = xb; c = xc;
    strt = 1'b1;
    @(posedge clk); #1;
    strt = 1'b0;
    if (scramble) begin
      for (int i = 0; i < 12 && !idle; i++) begin
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    int n0;
    #1;
    check("reset_product", 32'(product), 0);
    check("reset_idle", 32'(idle), 1);
    check("reset_done", 32'(done), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Directed cases
    run_op(8'd13, 8'd11, 8'd5, 1'b0);
    drain();
    check("basic_148", 32'(product), 148);
    run_op(8'd255, 8'd255, 8'd255, 1'b0);
    run_op(8'd0, 8'd200, 8'd7, 1'b0);
    run_op(8'd7, 8'd28, 8'd4, 1'b0);
    run_op(8'd255, 8'd0, 8'd0, 1'b0);
    run_op(8'd1, 8'd128, 8'd0, 1'b1);
    drain();

    // Held strt: back-to-back every 10 cycles
    wait_idle();
    n0 = accepts.size();
    a = 8'd37; b = 8'd201; c = 8'd99;
    strt = 1'b1;
    repeat (45) begin @(posedge clk); #1; end
    strt = 1'b0;
    check("b2b_enough_ops", 32'(accepts.size() - n0 >= 4), 1);
    for (int i = n0 + 1; i < accepts.size(); i++)
      check("b2b_spacing", 32'(accepts[i] - accepts[i-1]), 10);
    drain();

    // strt pulsed during CALC and DONE with operands changing
    wait_idle();
    n0 = accepts.size();
    a = 8'd100; b = 8'd3; c = 8'd9;
    strt = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      if (idle) break;
      strt = (i % 2 == 1);
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      @(posedge clk); #1;
    end
    strt = 1'b0;
    check("ignore_accepts", 32'(accepts.size() - n0), 1);
    check("ignore_product", 32'(product), 309);
    drain();

    // Asynchronous reset mid-CALC, between edges
    run_op(8'd200, 8'd200, 8'd200, 1'b0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    sb.delete();
    #1;
    check("abort_product", 32'(product), 0);
    check("abort_idle", 32'(idle), 1);
    check("abort_done", 32'(done), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    check("abort_no_done_product", 32'(product), 0);
    run_op(8'd9, 8'd9, 8'd0, 1'b0);
    drain();
    check("after_reset_81", 32'(product), 81);

    // Hold after completion
    run_op(8'd13, 8'd11, 8'd5, 1'b0);
    drain();
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      check("hold_product", 32'(product), 148);
      check("hold_done", 32'(done), 0);
    end

    // Random sweep against the arithmetic model
    for (int i = 0; i < 1000; i++)
      run_op(8'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
